bdc_frame_controller: RTL and testbench
=======================================

// Module: bdc_frame_controller
// PURPOSE
//  Frame-level sequencer in front of barrel_distortion_correction. Gates the input AXI-Stream so the core
//  only receives whole, well-formed frames, and repairs or flags framing errors. Applies K1 coefficient
//  updates only between frames. Watches the core output stream to detect frame drain, then counts frames.
// PARAMETERS
//  WIDTH          128      pixels per line
//  HEIGHT         100      lines per frame
//  DATA_WIDTH     24       pixel width (RGB888)
//  K1_DEFAULT     8'hE0    K1 after reset (signed 4.4)
//  DRAIN_TIMEOUT  65535    max cycles in DRAIN waiting for core output tlast
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   reset; synchronous, active-low
//  cfg_start      in   1   pulse: begin accepting frames
//  cfg_stop       in   1   pulse: stop after current frame (immediate if no frame in progress)
//  cfg_single     in   1   level: 1 = return to IDLE after each frame
//  cfg_k1         in   8   new K1 value
//  cfg_k1_we      in   1   pulse: write cfg_k1 into shadow register
//  s_axis_tdata   in   DATA_WIDTH  upstream pixel
//  s_axis_tvalid/tlast/tuser  in 1  upstream AXIS controls (tuser = SOF)
//  s_axis_tready  out  1   upstream ready
//  m_axis_tdata   out  DATA_WIDTH  to core input
//  m_axis_tvalid/tlast/tuser  out 1  to core input
//  m_axis_tready  in   1   core s_axis_tready
//  mon_tvalid/mon_tready/mon_tlast  in 1  tap of core output handshake
//  core_k1        out  8   active K1 to core DISTORTION input
//  busy           out  1   state != IDLE
//  frame_done     out  1   1-cycle pulse on drain completion
//  frame_err      out  1   1-cycle pulse on any framing error or timeout
//  frame_count    out  16  completed frames; wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: state=IDLE; s_axis_tready=0, m_axis_tvalid/tlast/tuser=0, busy/frame_done/frame_err=0,
//   frame_count=0, core_k1=K1_DEFAULT, shadow=K1_DEFAULT, k1_pending=0, stop_pending=0.
//   Reset mid-frame abandons the frame. The core is reset from the same rst_n.
//  States:
//   IDLE     s_tready=0. cfg_start goes to WAIT_SOF. cfg_start is ignored outside IDLE.
//   WAIT_SOF s_tready=1. Beats with tuser=0 are consumed and dropped, with no error.
//            A beat with valid&tuser is forwarded, and that cycle's s_tready=m_tready.
//            Handshake goes to IN_FRAME with x=1 (or x=0,y=1 when WIDTH=1).
//   IN_FRAME Zero-latency pass-through: m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready (comb).
//            x/y counters advance per handshake; last pixel = (x==WIDTH-1 && y==HEIGHT-1).
//            Mid-frame tuser=1: forward with m_tuser forced 0, pulse frame_err, continue.
//            tlast before last pixel: forward, pulse frame_err, go to DRAIN.
//            Last pixel without tlast: force m_tlast=1, pulse frame_err, go to DRAIN.
//            Last pixel with tlast: go to DRAIN.
//   DRAIN    s_tready=0, m_tvalid=0. On mon_tvalid&mon_tready&mon_tlast: pulse frame_done, frame_count++.
//            Then go to IDLE if cfg_single|stop_pending, else WAIT_SOF.
//            Timeout counter hits DRAIN_TIMEOUT: pulse frame_err, no count, go to IDLE.
//  Stop: cfg_stop in IDLE/WAIT_SOF goes to IDLE next cycle. In IN_FRAME/DRAIN it sets stop_pending,
//   which clears on entry to IDLE. cfg_start and cfg_stop in the same cycle: stop wins, stay IDLE.
//  K1: cfg_k1_we loads shadow and sets k1_pending. core_k1 <= shadow on entry to WAIT_SOF, or on the
//   cycle after the write if in IDLE. core_k1 never changes in IN_FRAME/DRAIN.
//   A write coinciding with the transfer: the new value is kept pending.
//  Error and done pulses are registered, one cycle after the causing beat. Error and done in the
//   same cycle both assert.
// STRUCTURE
//  bdc_pkg: state enum (IDLE,WAIT_SOF,IN_FRAME,DRAIN), K1_W=8, FRAME_PIXELS function, counter widths
//   ($clog2).
//  Sub-module bdc_xy_counter: x/y counter with enable, clear, wrap, last_pixel flag.
//  Rest is one FSM plus comb pass-through mux.
// TESTING (WIDTH=8, HEIGHT=4, DRAIN_TIMEOUT=100, mon stream = core model delaying tlast 20 cycles)
//  1 start, clean 32-pixel frame, cfg_single=0 -> 32 beats forwarded unchanged, frame_done once,
//    frame_count=1, back in WAIT_SOF.
//  2 3 junk beats (tuser=0) then frame -> junk never appears on m_axis, no frame_err, first m beat has
//    tuser=1.
//  3 tlast on pixel 20 -> frame_err pulse, state DRAIN, s_tready=0; no tlast on pixel 31 -> m_tlast
//    forced 1 and frame_err.
//  4 cfg_k1_we=1, cfg_k1=8'hC0 mid-frame -> core_k1 stays E0 until DRAIN->WAIT_SOF, then C0.
//  5 cfg_stop mid-frame -> frame completes, frame_done, then IDLE; start+stop same cycle -> stays IDLE.
//  6 no mon_tlast after frame -> frame_err after 100 DRAIN cycles, IDLE, frame_count unchanged;
//    m_tready stalls in IN_FRAME hold all data.

Source files
------------

// File: rtl/bdc_pkg.sv
// Shared definitions for the barrel-distortion frame controller: state encodings,
// coefficient width and counter sizing helpers.
package bdc_pkg;

  localparam int unsigned K1_W = 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_IN_FRAME = 2'd2;
  localparam logic [1:0] ST_DRAIN    = 2'd3;

  function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bdc_xy_counter.sv
// Raster-position counter: x advances per accepted pixel, y per completed line,
// both wrap at the frame end; flags the final pixel of the frame.
module bdc_xy_counter
  import bdc_pkg::*;
#(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned HEIGHT = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last_pixel_c
);

  localparam int unsigned XW = cnt_w(WIDTH);
  localparam int unsigned YW = cnt_w(HEIGHT);
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign last_pixel_c = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/bdc_frame_controller.sv
// Frame sequencer in front of the distortion core: admits only whole frames, repairs
// or flags framing errors, swaps K1 between frames and counts drained frames.
module bdc_frame_controller
  import bdc_pkg::*;
#(
  parameter int unsigned     WIDTH         = 128,
  parameter int unsigned     HEIGHT        = 100,
  parameter int unsigned     DATA_WIDTH    = 24,
  parameter logic [K1_W-1:0] K1_DEFAULT    = 8'hE0,
  parameter int unsigned     DRAIN_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic                  cfg_single,
  input  logic [K1_W-1:0]       cfg_k1,
  input  logic                  cfg_k1_we,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  input  logic                  mon_tvalid,
  input  logic                  mon_tready,
  input  logic                  mon_tlast,
  output logic [K1_W-1:0]       core_k1,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [15:0]           frame_count
);

  localparam int unsigned TW = cnt_w(DRAIN_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DRAIN_TIMEOUT - 1);

  logic [1:0]      state, state_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic [K1_W-1:0] shadow_k1;
  logic            k1_pending, stop_pending;
  logic            last_pixel_c, beat_c, err_c, done_c, k1_load_c, xy_clr_c;

  bdc_xy_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_xy (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (xy_clr_c),
    .en           (beat_c),
    .last_pixel_c (last_pixel_c)
  );

  assign xy_clr_c = (state == ST_IDLE) || (state == ST_DRAIN);

  // Next state, stream gating and error/done detection.
  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    beat_c        = 1'b0;
    err_c         = 1'b0;
    done_c        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_start && !cfg_stop) state_nxt = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        s_axis_tready = 1'b1;
        if (cfg_stop) state_nxt = ST_IDLE;
        if (s_axis_tvalid && s_axis_tuser) begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = 1'b1;
          m_axis_tuser  = 1'b1;
          m_axis_tlast  = s_axis_tlast || last_pixel_c;
          beat_c        = m_axis_tready;
          if (beat_c) state_nxt = ST_IN_FRAME;
        end
      end
      ST_IN_FRAME: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast || last_pixel_c;
        beat_c        = s_axis_tvalid && m_axis_tready;
        if (beat_c && s_axis_tuser) err_c = 1'b1;
      end
      ST_DRAIN: begin
        if (mon_tvalid && mon_tready && mon_tlast) begin
          done_c    = 1'b1;
          state_nxt = (cfg_single || stop_pending || cfg_stop) ? ST_IDLE : ST_WAIT_SOF;
        end else if (tmo_cnt == TMO_LAST) begin
          err_c     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Frame ends on either tlast or the geometric last pixel; disagreement is an error.
    if (beat_c && (s_axis_tlast || last_pixel_c)) begin
      state_nxt = ST_DRAIN;
      if (s_axis_tlast != last_pixel_c) err_c = 1'b1;
    end
  end

  // K1 may only move while no frame is inside the core.
  assign k1_load_c = k1_pending &&
                     ((state == ST_IDLE) || ((state_nxt == ST_WAIT_SOF) && (state != ST_WAIT_SOF)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      tmo_cnt      <= '0;
      shadow_k1    <= K1_DEFAULT;
      core_k1      <= K1_DEFAULT;
      k1_pending   <= 1'b0;
      stop_pending <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      frame_count  <= '0;
    end else begin
      state        <= state_nxt;
      tmo_cnt      <= (state == ST_DRAIN) ? tmo_cnt + TW'(1) : '0;
      stop_pending <= (state_nxt == ST_IDLE) ? 1'b0 : (stop_pending || cfg_stop);
      busy         <= (state_nxt != ST_IDLE);
      frame_done   <= done_c;
      frame_err    <= err_c;
      frame_count  <= frame_count + 16'(done_c);
      if (k1_load_c) core_k1 <= shadow_k1;
      if (cfg_k1_we) begin
        shadow_k1  <= cfg_k1;
        k1_pending <= 1'b1;
      end else if (k1_load_c) begin
        k1_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bdc_frame_controller.sv
// Randomized bench for bdc_frame_controller against a frame-level reference model
// and a simple core model that returns tlast a fixed delay after it enters.
`timescale 1ns/1ps
module tb_bdc_frame_controller;

  localparam int W = 8, H = 4, DW = 24, TMO = 100, NPIX = W * H, CORE_LAT = 20;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cfg_start = 1'b0, cfg_stop = 1'b0, cfg_single = 1'b0, cfg_k1_we = 1'b0;
  logic [7:0]    cfg_k1 = 8'h00;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic          m_axis_tready = 1'b1;
  logic          mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
  logic [7:0]    core_k1;
  logic          busy, frame_done, frame_err;
  logic [15:0]   frame_count;

  bdc_frame_controller #(
    .WIDTH (W), .HEIGHT (H), .DATA_WIDTH (DW), .K1_DEFAULT (8'hE0), .DRAIN_TIMEOUT (TMO)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .cfg_start (cfg_start), .cfg_stop (cfg_stop), .cfg_single (cfg_single),
    .cfg_k1 (cfg_k1), .cfg_k1_we (cfg_k1_we),
    .s_axis_tdata (s_axis_tdata), .s_axis_tvalid (s_axis_tvalid), .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser), .s_axis_tready (s_axis_tready),
    .m_axis_tdata (m_axis_tdata), .m_axis_tvalid (m_axis_tvalid), .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser), .m_axis_tready (m_axis_tready),
    .mon_tvalid (mon_tvalid), .mon_tready (mon_tready), .mon_tlast (mon_tlast),
    .core_k1 (core_k1), .busy (busy), .frame_done (frame_done), .frame_err (frame_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0, n_mis = 0, cyc = 0;
  int    err_seen = 0, done_seen = 0, exp_err = 0, exp_done = 0, exp_count = 0;
  bit    stall_en = 1'b0, mon_en = 1'b1;
  beat_t got_q[$], exp_q[$];
  int    mon_due[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core model: random input backpressure, output tlast CORE_LAT cycles after input tlast.
  always @(posedge clk) begin
    cyc++;
    #1;
    m_axis_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    if (mon_due.size() != 0 && mon_due[0] <= cyc) begin
      void'(mon_due.pop_front());
      mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
    end
  end

  // Observe everything mid-cycle, when inputs and registered outputs are stable.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      got_q.push_back('{d: m_axis_tdata, u: m_axis_tuser, l: m_axis_tlast});
      if (m_axis_tlast && mon_en) mon_due.push_back(cyc + CORE_LAT);
    end
    if (frame_err) err_seen++;
    if (frame_done) done_seen++;
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
    int k = 0;
    @(posedge clk); #2;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && k < 300) begin
      k++;
      @(negedge clk);
    end
    if (!s_axis_tready) check("s_ready_wait", 32'(s_axis_tready), 32'd1);
    @(posedge clk); #2;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_evt(input int evt);
    if (evt == 1) begin
      @(posedge clk); #2; cfg_k1 = 8'hC0; cfg_k1_we = 1'b1;
      @(posedge clk); #2; cfg_k1_we = 1'b0;
      @(negedge clk); check("k1_hold_mid_frame", 32'(core_k1), 32'hE0);
    end else if (evt == 2) begin
      @(posedge clk); #2; cfg_stop = 1'b1;
      @(posedge clk); #2; cfg_stop = 1'b0;
    end
  endtask

  // Reference: a frame ends at tlast or the 32nd pixel, whichever first; SOF tuser only on
  // pixel 0; any stray tuser or tlast/geometry disagreement costs one error pulse.
  task automatic send_frame(input int last_at, input int user_at, input int evt_at, input int evt);
    logic [DW-1:0] d;
    logic u, l, fin;
    for (int p = 0; p < NPIX; p++) begin
      d   = DW'($urandom);
      u   = (p == 0) || (p == user_at);
      l   = (p == last_at);
      fin = l || (p == NPIX - 1);
      exp_q.push_back('{d: d, u: (p == 0), l: fin});
      if ((p != 0 && u) || (l != (p == NPIX - 1))) exp_err++;
      send_beat(d, u, l);
      if (p == evt_at) do_evt(evt);
      if (fin) break;
    end
  endtask

  task automatic wait_events(input string tag);
    int k = 0;
    while ((done_seen < exp_done || err_seen < exp_err) && k < 600) begin
      k++;
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done_seen), 32'(exp_done));
    check({tag, "_err"}, 32'(err_seen), 32'(exp_err));
    check({tag, "_count"}, 32'(frame_count), 32'(exp_count));
  endtask

  task automatic cmp_frames(input string tag);
    beat_t g, e;
    check({tag, "_nbeats"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_beat"}, 32'(g), 32'(e));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #2; cfg_start = 1'b1;
    @(posedge clk); #2; cfg_start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int last_at, input int user_at,
                           input int evt_at, input int evt);
    send_frame(last_at, user_at, evt_at, evt);
    exp_done++;
    exp_count++;
    wait_events(tag);
    cmp_frames(tag);
  endtask

  initial begin
    int lat, r, last_at, user_at;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", 32'(s_axis_tready), 0);
    check("rst_m_tvalid", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tuser}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pulses", 32'({frame_done, frame_err}), 0);
    check("rst_count", 32'(frame_count), 0);
    check("rst_core_k1", 32'(core_k1), 32'hE0);
    @(posedge clk); #2; rst_n = 1'b1;

    // Clean frame, continuous mode.
    pulse_start();
    run_frame("clean", -1 + NPIX, -1, -1, 0);
    check("clean_back_wait_sof", 32'({busy, s_axis_tready}), 32'b11);

    // Junk before SOF is dropped silently; stalls on the core side.
    for (int j = 0; j < 3; j++) send_beat(DW'($urandom), 1'b0, 1'b0);
    check("junk_not_forwarded", 32'(got_q.size()), 0);
    check("junk_no_err", 32'(err_seen), 32'(exp_err));
    stall_en = 1'b1;
    run_frame("after_junk", NPIX - 1, -1, -1, 0);
    stall_en = 1'b0;

    // Early tlast, then missing tlast.
    send_frame(20, -1, -1, 0);
    @(negedge clk);
    check("early_tlast_err", 32'(frame_err), 1);
    check("early_tlast_drain", 32'({busy, s_axis_tready}), 32'b10);
    exp_done++; exp_count++;
    wait_events("early_tlast");
    cmp_frames("early_tlast");
    send_frame(-1, -1, -1, 0);
    @(negedge clk);
    check("no_tlast_err", 32'(frame_err), 1);
    exp_done++; exp_count++;
    wait_events("no_tlast");
    cmp_frames("no_tlast");

    // K1 written mid-frame only lands once the frame has drained.
    send_frame(NPIX - 1, -1, 10, 1);
    @(negedge clk);
    check("k1_hold_drain", 32'(core_k1), 32'hE0);
    exp_done++; exp_count++;
    wait_events("k1");
    cmp_frames("k1");
    check("k1_applied", 32'(core_k1), 32'hC0);

    // Randomized framing faults under backpressure.
    stall_en = 1'b1;
    for (int f = 0; f < 5; f++) begin
      r = int'($urandom_range(0, 3));
      last_at = (r == 0) ? int'($urandom_range(1, NPIX - 2)) : (r == 1) ? -1 : NPIX - 1;
      user_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NPIX - 1)) : -1;
      run_frame("rand", last_at, user_at, -1, 0);
    end
    stall_en = 1'b0;

    // Stop mid-frame completes the frame and then idles.
    run_frame("stop", NPIX - 1, -1, 5, 2);
    check("stop_idle", 32'(busy), 0);
    @(posedge clk); #2; cfg_start = 1'b1; cfg_stop = 1'b1;
    @(posedge clk); #2; cfg_start = 1'b0; cfg_stop = 1'b0;
    @(negedge clk);
    check("start_stop_idle", 32'({busy, s_axis_tready}), 0);
    r = int'($urandom_range(0, 255));
    @(posedge clk); #2; cfg_k1 = 8'(r); cfg_k1_we = 1'b1;
    @(posedge clk); #2; cfg_k1_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("k1_idle_write", 32'(core_k1), 32'(r));

    // Core never returns tlast: drain timeout.
    pulse_start();
    mon_en = 1'b0;
    send_frame(NPIX - 1, -1, -1, 0);
    exp_err++;
    lat = 0;
    while (err_seen < exp_err && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("tmo_err", 32'(err_seen), 32'(exp_err));
    check("tmo_latency_ok", 32'(lat >= TMO - 5 && lat <= TMO + 5), 1);
    check("tmo_idle", 32'(busy), 0);
    check("tmo_count", 32'(frame_count), 32'(exp_count));
    check("tmo_no_done", 32'(done_seen), 32'(exp_done));
    cmp_frames("tmo");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
